serial_borrow_skip_subtractor: RTL and testbench
================================================

// Module: serial_borrow_skip_subtractor
// PURPOSE
//   Multi-cycle subtractor: diff = a - b - bin over N bits, one 4-bit block per cycle, LSB block first.
//   Borrow is registered between blocks. Early exit ("borrow skip") when the carried borrow is 0 and every
//   remaining b block is 0; remaining a blocks are then copied straight into diff.
//   Inverse-direction companion to the datapath adders; sits behind a valid/ready ALU issue port.
// PARAMETERS
//   N     32   operand width; multiple of 4, >= 8 (NB = N/4 blocks)
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   in_valid   in   1   operands valid
//   in_ready   out  1   block can accept operands
//   a          in   N   minuend
//   b          in   N   subtrahend
//   bin        in   1   borrow in
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts result
//   diff       out  N   a - b - bin, mod 2^N
//   bout       out  1   final borrow (1 = a < b + bin, unsigned)
//   overflow   out  1   signed overflow of a - b - bin
//   early      out  1   result finished via borrow skip before block NB-1
// BEHAVIOUR
//   - Reset: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, overflow=0, early=0, idx=0.
//     rst wins over every other event; reset mid-RUN/DONE discards the operation with no output.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//     IDLE: in_ready=1. On in_valid: latch a, b, set borrow=bin, idx=0, early=0, go RUN.
//     RUN: in_ready=0. Each cycle: t = {1'b0,a[4i+3:4i]} - {1'b0,b[4i+3:4i]} - borrow (5 bit), i=idx.
//       diff[4i+3:4i] <= t[3:0]; borrow <= t[4].
//       If idx==NB-1 -> DONE, early=0.
//       Else if t[4]==0 and b[N-1:4(i+1)]==0 -> diff[N-1:4(i+1)] <= a[N-1:4(i+1)], early=1, DONE.
//       Else idx <= idx+1.
//     DONE: out_valid=1; on out_ready -> IDLE (in_ready=1 next cycle). No same-cycle accept.
//   - bout = borrow after the final processed block (0 on early exit).
//   - overflow = (a[N-1]^b[N-1]) & (a[N-1]^diff[N-1]), from latched operands; 0 on early exit.
//   - Latency: accept at edge 0, k RUN cycles (1 <= k <= NB), out_valid high from cycle k+1.
//   - diff/bout/overflow/early registered; stable while out_valid && !out_ready.
//   - in_valid ignored outside IDLE; a/b/bin may change freely after acceptance.
//   - Block 0 always processed (bin may be 1). A skip-check hit on block NB-2 still sets early=1.
// TESTING
//   1. N=32, a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, bout=0, ov=0, early=1, out_valid at cycle 2.
//   2. a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, ov=0, early=0, 8 RUN cycles.
//   3. a=0x80000000, b=0x00000001, bin=0 -> diff=0x7FFFFFFF, bout=0, ov=1, early=0, 8 RUN cycles.
//   4. a=b=0x12345678, bin=1 -> diff=0xFFFFFFFF, bout=1, ov=0, early=0.
//   5. Result pending, out_ready=0 for 10 cycles, in_valid=1 -> outputs frozen, in_ready=0, no new accept.
//   6. rst=1 at RUN cycle 3 -> next cycle IDLE, in_ready=1, out_valid=0, diff=0; next op correct.

Source files
------------

// File: rtl/serial_borrow_skip_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_borrow_skip_subtractor
//  Purpose  : Multi-cycle subtractor computing diff = a - b - bin, mod 2^N.
//             Works on one 4-bit block per cycle, LSB block first, with the
//             borrow registered between blocks. The operation finishes early
//             ("borrow skip") when the carried borrow is 0 and every remaining
//             subtrahend block is 0. The remaining minuend blocks are then
//             copied straight into diff.
//  Ports    : clk, rst          - clock (rising edge), synchronous active-high reset
//             in_valid/in_ready - operand handshake (a, b, bin)
//             out_valid/out_ready - result handshake (diff, bout, overflow, early)
//             diff              - a - b - bin, mod 2^N
//             bout              - final unsigned borrow
//             overflow          - signed overflow of a - b - bin
//             early             - result completed through borrow skip
//  Revision : 1.0 - initial release
// ============================================================================
module serial_borrow_skip_subtractor #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         overflow,
  output logic         early
);

  localparam int NB = N / 4;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic            borrow_q;
  logic [IW-1:0]   idx_q;
  logic [N-1:0]    diff_q;
  logic            bout_q;
  logic            ovf_q;
  logic            early_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [4:0]      w_t;
  logic            w_last;
  logic [SW-1:0]   w_shamt;
  logic [N-1:0]    w_hi_mask;
  logic            w_skip;
  logic [N-1:0]    w_diff_blk;
  logic [N-1:0]    w_diff_run;

  // Block subtraction for the current index; bit 4 is the outgoing borrow.
  assign w_t = {1'b0, a_q[{idx_q, 2'b00} +: 4]}
             - {1'b0, b_q[{idx_q, 2'b00} +: 4]}
             - {4'b0000, borrow_q};

  assign w_last = (idx_q == IW'(NB - 1));

  // Mask of all bits above the current block. On the last block the shift
  // equals N and the mask is empty, so the skip check never fires there.
  assign w_shamt   = SW'({idx_q, 2'b00}) + SW'(4);
  assign w_hi_mask = {N{1'b1}} << w_shamt;
  assign w_skip    = !w_t[4] && ((b_q & w_hi_mask) == '0) && !w_last;

  always_comb begin
    w_diff_blk = diff_q;
    w_diff_blk[{idx_q, 2'b00} +: 4] = w_t[3:0];
  end

  // With no borrow left and nothing more to subtract, the upper result bits
  // are just the upper minuend bits.
  assign w_diff_run = w_skip ? ((w_diff_blk & ~w_hi_mask) | (a_q & w_hi_mask))
                             : w_diff_blk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      idx_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      early_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            borrow_q   <= bin;
            idx_q      <= '0;
            early_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          diff_q   <= w_diff_run;
          borrow_q <= w_t[4];
          if (w_last) begin
            bout_q      <= w_t[4];
            // w_t[3] is the final diff MSB.
            ovf_q       <= (a_q[N-1] ^ b_q[N-1]) & (a_q[N-1] ^ w_t[3]);
            early_q     <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (w_skip) begin
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            early_q     <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign overflow  = ovf_q;
  assign early     = early_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_borrow_skip_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_borrow_skip_subtractor
//  Purpose  : Self-checking bench for serial_borrow_skip_subtractor (N=32).
//             Directed vectors, randomized operations against an arithmetic
//             reference model, backpressure, back-to-back and mid-run reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_borrow_skip_subtractor;

  localparam int N  = 32;
  localparam int NB = N / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         overflow;
  logic         early;

  int n_vec  = 0;
  int n_fail = 0;

  serial_borrow_skip_subtractor #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow),
    .early    (early)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the whole operands.
  task automatic ref_model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mbin,
                           output logic [N-1:0] rd, output logic rb, output logic rov,
                           output logic re, output int rk);
    logic [63:0] lm;
    logic        brw;
    longint      res;
    rd  = ma - mb - N'(mbin);
    rb  = ({1'b0, ma} < ({1'b0, mb} + (N+1)'(mbin)));
    res = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
    rov = (res > 64'sd2147483647) || (res < -64'sd2147483648);
    re  = 1'b0;
    rk  = NB;
    for (int i = 0; i < NB - 1; i++) begin
      lm  = 64'd1 << (4 * (i + 1));
      brw = (64'(ma) % lm) < ((64'(mb) % lm) + 64'(mbin));
      if (!brw && ((64'(mb) >> (4 * (i + 1))) == 64'd0)) begin
        re = 1'b1;
        rk = i + 1;
        break;
      end
    end
  endtask

  // Presents one operand set and waits (bounded) for the result.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ibin,
                       output int cyc);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    a = ia; b = ib; bin = ibin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 4 * NB) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_vec++; if (in_ready  !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_vec++; if (diff      !== '0)   begin n_fail++; $display("FAIL reset_diff got %h exp 0", diff); end
    n_vec++; if (bout      !== 1'b0) begin n_fail++; $display("FAIL reset_bout got %b exp 0", bout); end
    n_vec++; if (overflow  !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    n_vec++; if (early     !== 1'b0) begin n_fail++; $display("FAIL reset_early got %b exp 0", early); end
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [4] = '{32'h00000005, 32'h00000000, 32'h80000000, 32'h12345678};
    logic [N-1:0] tb [4] = '{32'h00000003, 32'h00000001, 32'h00000001, 32'h12345678};
    logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] ed [4] = '{32'h00000002, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic         eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic         eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic         ee [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int           ek [4] = '{1, 8, 8, 8};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i], tc[i], cyc);
      n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid got %b exp 1", i, out_valid); end
      n_vec++; if (cyc !== ek[i]) begin n_fail++; $display("FAIL dir%0d_latency got %0d exp %0d", i, cyc, ek[i]); end
      n_vec++; if (diff !== ed[i]) begin n_fail++; $display("FAIL dir%0d_diff got %h exp %h", i, diff, ed[i]); end
      n_vec++; if (bout !== eb[i]) begin n_fail++; $display("FAIL dir%0d_bout got %b exp %b", i, bout, eb[i]); end
      n_vec++; if (overflow !== eo[i]) begin n_fail++; $display("FAIL dir%0d_ov got %b exp %b", i, overflow, eo[i]); end
      n_vec++; if (early !== ee[i]) begin n_fail++; $display("FAIL dir%0d_early got %b exp %b", i, early, ee[i]); end
      release_result();
    end
  endtask

  task automatic test_random(input int nops);
    logic [N-1:0] ra, rb_, md;
    logic         rc, mb, mo, me;
    int           mk, cyc, hold;
    logic [N-1:0] snap;
    for (int i = 0; i < nops; i++) begin
      ra  = $urandom;
      rb_ = $urandom;
      // Narrow the subtrahend most of the time so borrow skip is exercised.
      if ($urandom_range(0, 3) != 0) rb_ = rb_ >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) ra = ra >> $urandom_range(0, 31);
      rc = 1'($urandom);
      ref_model(ra, rb_, rc, md, mb, mo, me, mk);
      issue(ra, rb_, rc, cyc);
      n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_valid got %b exp 1", i, out_valid); end
      n_vec++; if (cyc !== mk) begin n_fail++; $display("FAIL rnd%0d_latency a=%h b=%h got %0d exp %0d", i, ra, rb_, cyc, mk); end
      n_vec++; if (diff !== md) begin n_fail++; $display("FAIL rnd%0d_diff a=%h b=%h bin=%b got %h exp %h", i, ra, rb_, rc, diff, md); end
      n_vec++; if (bout !== mb) begin n_fail++; $display("FAIL rnd%0d_bout got %b exp %b", i, bout, mb); end
      n_vec++; if (overflow !== mo) begin n_fail++; $display("FAIL rnd%0d_ov got %b exp %b", i, overflow, mo); end
      n_vec++; if (early !== me) begin n_fail++; $display("FAIL rnd%0d_early got %b exp %b", i, early, me); end
      hold = $urandom_range(0, 3);
      snap = diff;
      repeat (hold) @(negedge clk);
      n_vec++; if (diff !== snap || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_hold got %h/%b exp %h/1", i, diff, out_valid, snap);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] md;
    logic         mb, mo, me;
    int           mk, cyc;
    ref_model(32'h00000000, 32'h00000001, 1'b0, md, mb, mo, me, mk);
    issue(32'h00000000, 32'h00000001, 1'b0, cyc);
    in_valid = 1'b1; a = 32'h0000FFFF; b = 32'h00000001; bin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp%0d_handshake got valid=%b ready=%b exp 1/0", i, out_valid, in_ready);
      end
      n_vec++; if (diff !== md || bout !== mb || overflow !== mo || early !== me) begin
        n_fail++; $display("FAIL bp%0d_frozen got %h %b %b %b exp %h %b %b %b", i, diff, bout, overflow, early, md, mb, mo, me);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after got %b exp 1", in_ready); end
    repeat (3) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back(input int nops);
    logic [N-1:0] ra, rb_, md;
    logic         rc, mb, mo, me;
    int           mk, cyc;
    for (int i = 0; i < nops; i++) begin
      ra = $urandom; rb_ = $urandom >> $urandom_range(0, 31); rc = 1'($urandom);
      ref_model(ra, rb_, rc, md, mb, mo, me, mk);
      issue(ra, rb_, rc, cyc);
      n_vec++; if (diff !== md || bout !== mb || overflow !== mo || early !== me || cyc !== mk) begin
        n_fail++; $display("FAIL b2b%0d got %h %b %b %b k=%0d exp %h %b %b %b k=%0d",
                           i, diff, bout, overflow, early, cyc, md, mb, mo, me, mk);
      end
      release_result();
      n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_ready got %b exp 1", i, in_ready); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] md;
    logic         mb, mo, me;
    int           mk, cyc;
    a = 32'h00000000; b = 32'h00000001; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b exp 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    n_vec++; if (diff !== '0) begin n_fail++; $display("FAIL rmid_diff got %h exp 0", diff); end
    repeat (10) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_output got %b exp 0", out_valid); end
    ref_model(32'hDEADBEEF, 32'h0000BEEF, 1'b1, md, mb, mo, me, mk);
    issue(32'hDEADBEEF, 32'h0000BEEF, 1'b1, cyc);
    n_vec++; if (diff !== md || bout !== mb || overflow !== mo || early !== me || cyc !== mk) begin
      n_fail++; $display("FAIL rmid_next got %h %b %b %b k=%0d exp %h %b %b %b k=%0d",
                         diff, bout, overflow, early, cyc, md, mb, mo, me, mk);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(150);
    test_backpressure();
    test_back_to_back(20);
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
